seg7_scan_driver: RTL and testbench

- Consumes the four BCD time digits (tenmin, onemin, tensec, onesec) produced by the watch's timekeeping blocks.
- Drives the board's 4-digit common-anode seven-segment display by time-multiplexed scanning.
- Latches digits once per scan frame to prevent tearing, and adds colon, blink and blanking controls.
- Sits between the timer/clock mode mux and the top-level display pins.

---
 rtl/seg7_scan_driver.sv | 126 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Purpose: scans four BCD digits onto a common-anode 7-segment display, with colon, blink and blanking.
// Latency: one registered cycle from scan index/shadow digits to an/seg/dp; inputs are latched once per frame.
// Backpressure: none (free-running display sink). Optional macro LEADING_ZERO_BLANK_EN blanks leading minutes zeros.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic       clk100MHz,
    input  logic       rst_n,
    input  logic [3:0] tenmin,
    input  logic [3:0] onemin,
    input  logic [3:0] tensec,
    input  logic [3:0] onesec,
    input  logic       display_en,
    input  logic       blink_en,
    input  logic       colon_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0] refresh_cnt;
    logic [1:0]    scan_idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [3:0]    sh3, sh2, sh1, sh0;
    logic          slot_tick;
    logic [3:0]    sel_digit;
    logic          dark;
    logic          blank_sel;

    assign slot_tick = (refresh_cnt == RW'(REFRESH_DIV - 1));

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = 7'b0111111;
        endcase
    endfunction

    // Shadow digits only change at the end of position 3, so a frame never tears.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
            frame_tick  <= 1'b0;
            sh3         <= 4'd0;
            sh2         <= 4'd0;
            sh1         <= 4'd0;
            sh0         <= 4'd0;
        end else begin
            frame_tick <= 1'b0;
            if (slot_tick) begin
                refresh_cnt <= '0;
                scan_idx    <= scan_idx + 2'd1;
                if (scan_idx == 2'd3) begin
                    sh3        <= tenmin;
                    sh2        <= onemin;
                    sh1        <= tensec;
                    sh0        <= onesec;
                    frame_tick <= 1'b1;
                end
            end else begin
                refresh_cnt <= refresh_cnt + RW'(1);
            end
        end
    end

    // Counter held and phase forced visible while blinking is off.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_comb begin
        case (scan_idx)
            2'd0:    sel_digit = sh0;
            2'd1:    sel_digit = sh1;
            2'd2:    sel_digit = sh2;
            default: sel_digit = sh3;
        endcase
        dark = !display_en || (blink_en && !blink_phase);
`ifdef LEADING_ZERO_BLANK_EN
        blank_sel = ((scan_idx == 2'd3) && (sh3 == 4'd0)) ||
                    ((scan_idx == 2'd2) && (sh3 == 4'd0) && (sh2 == 4'd0));
`else
        blank_sel = 1'b0;
`endif
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= (dark || blank_sel) ? 4'b1111 : ~(4'b0001 << scan_idx);
            seg <= dec7(sel_digit);
            dp  <= !(colon_en && (scan_idx == 2'd2) && !dark && !blank_sel);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, BLINK_DIV=8.
module tb_seg7_scan_driver;

    localparam int RD = 4;
    localparam int BD = 8;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk100MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tenmin = 4'd0, onemin = 4'd0, tensec = 4'd0, onesec = 4'd0;
    logic       display_en = 1'b1, blink_en = 1'b0, colon_en = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int tests_run = 0;
    int tests_failed = 0;

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .tenmin    (tenmin),
        .onemin    (onemin),
        .tensec    (tensec),
        .onesec    (onesec),
        .display_en(display_en),
        .blink_en  (blink_en),
        .colon_en  (colon_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    always #5 clk100MHz = ~clk100MHz;

    // Returns on the negedge where frame_tick is seen high, or after a bounded wait.
    task automatic wait_frame(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk100MHz);
            if (frame_tick) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        rst_n = 1'b0;
        tenmin = 4'd1; onemin = 4'd2; tensec = 4'd3; onesec = 4'd4;
        #12;
        tests_run++;
        if ({an, seg, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_values: an=%b seg=%b dp=%b ft=%b, required 1111 1111111 1 0", an, seg, dp, frame_tick);
        end
        @(negedge clk100MHz);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk100MHz);
            ea = ~(4'b0001 << (i / 4));
            tests_run++;
            if ({an, seg, frame_tick} !== {ea, 7'b1000000, (i == 15)}) begin
                tests_failed++;
                $display("FAIL post_reset cyc%0d: an=%b seg=%b ft=%b, required %b 1000000 %b", i, an, seg, frame_tick, ea, (i == 15));
            end
        end
    endtask

    task automatic test_scan();
        bit seen;
        logic [6:0] es [4];
        logic [3:0] ea;
        es[0] = 7'b0011001; es[1] = 7'b0110000; es[2] = 7'b0100100; es[3] = 7'b1111001;
        wait_frame(seen);
        tests_run++;
        if (seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL scan_frame_wait: frame_tick never seen, required within 40 cycles");
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk100MHz);
            ea = ~(4'b0001 << (i / 4));
            tests_run++;
            if ({an, seg, dp, frame_tick} !== {ea, es[i/4], 1'b1, (i == 15)}) begin
                tests_failed++;
                $display("FAIL scan cyc%0d: an=%b seg=%b dp=%b ft=%b, required %b %b 1 %b", i, an, seg, dp, frame_tick, ea, es[i/4], (i == 15));
            end
        end
    endtask

    task automatic test_midframe_change();
        bit seen;
        logic [6:0] es;
        wait_frame(seen);
        repeat (5) @(negedge clk100MHz);
        onesec = 4'd7;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk100MHz);
            case (an)
                4'b1101: es = 7'b0110000;
                4'b1011: es = 7'b0100100;
                4'b0111: es = 7'b1111001;
                default: es = 7'bxxxxxxx;
            endcase
            tests_run++;
            if ((an === 4'b1110) || (seg !== es)) begin
                tests_failed++;
                $display("FAIL midframe_old cyc%0d: an=%b seg=%b, required an!=1110 seg=%b", i, an, seg, es);
            end
            if (frame_tick) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL midframe_frame_wait: frame_tick never seen, required within 20 cycles");
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk100MHz);
            es = (i < 4) ? 7'b1111000 : (i < 8) ? 7'b0110000 : 7'b0100100;
            tests_run++;
            if ({an, seg} !== {~(4'b0001 << (i / 4)), es}) begin
                tests_failed++;
                $display("FAIL midframe_new cyc%0d: an=%b seg=%b, required %b %b", i, an, seg, ~(4'b0001 << (i / 4)), es);
            end
        end
    endtask

    task automatic test_non_bcd_colon();
        bit seen;
        logic [6:0] es [4];
        logic [3:0] ea;
        logic       edp;
        es[0] = 7'b0111111; es[1] = 7'b0110000; es[2] = 7'b0100100; es[3] = 7'b1111001;
        @(negedge clk100MHz);
        onesec = 4'hC;
        colon_en = 1'b1;
        wait_frame(seen);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk100MHz);
            ea = ~(4'b0001 << (i / 4));
            edp = (i / 4 == 2) ? 1'b0 : 1'b1;
            tests_run++;
            if ({an, seg, dp} !== {ea, es[i/4], edp}) begin
                tests_failed++;
                $display("FAIL dash_colon cyc%0d: an=%b seg=%b dp=%b, required %b %b %b", i, an, seg, dp, ea, es[i/4], edp);
            end
        end
    endtask

    task automatic test_blink();
        bit exp_dark;
        @(negedge clk100MHz);
        blink_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk100MHz);
            exp_dark = (i >= 8) && (i < 16);
            tests_run++;
            if (((an === 4'b1111) !== exp_dark) || (exp_dark && (dp !== 1'b1))) begin
                tests_failed++;
                $display("FAIL blink cyc%0d: an=%b dp=%b, required dark=%b", i, an, dp, exp_dark);
            end
        end
        repeat (4) @(negedge clk100MHz);
        tests_run++;
        if (an !== 4'b1111) begin
            tests_failed++;
            $display("FAIL blink_second_dark: an=%b, required 1111", an);
        end
        blink_en = 1'b0;
        @(negedge clk100MHz);
        tests_run++;
        if (an === 4'b1111) begin
            tests_failed++;
            $display("FAIL blink_off_lit: an=%b, required one digit lit", an);
        end
        display_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk100MHz);
            tests_run++;
            if ({an, dp} !== {4'b1111, 1'b1}) begin
                tests_failed++;
                $display("FAIL display_off cyc%0d: an=%b dp=%b, required 1111 1", i, an, dp);
            end
        end
        display_en = 1'b1;
    endtask

    task automatic test_leading_zero();
        bit seen;
        bit blank;
        logic [6:0] es [4];
        logic [3:0] ea;
        logic       edp;
        for (int pat = 0; pat < 2; pat++) begin
            @(negedge clk100MHz);
            tenmin = 4'd0; onemin = (pat == 0) ? 4'd0 : 4'd3; tensec = 4'd0; onesec = 4'd5;
            es[0] = 7'b0010010; es[1] = 7'b1000000;
            es[2] = (pat == 0) ? 7'b1000000 : 7'b0110000; es[3] = 7'b1000000;
            wait_frame(seen);
            for (int i = 0; i < 16; i++) begin
                @(negedge clk100MHz);
                blank = LZB && ((i / 4 == 3) || (i / 4 == 2 && pat == 0));
                ea = blank ? 4'b1111 : ~(4'b0001 << (i / 4));
                edp = (i / 4 == 2 && !blank) ? 1'b0 : 1'b1;
                tests_run++;
                if ({an, seg, dp} !== {ea, es[i/4], edp}) begin
                    tests_failed++;
                    $display("FAIL lzb p%0d cyc%0d: an=%b seg=%b dp=%b, required %b %b %b", pat, i, an, seg, dp, ea, es[i/4], edp);
                end
            end
        end
    endtask

    task automatic test_reset_midscan();
        bit seen;
        logic [3:0] ea;
        wait_frame(seen);
        repeat (10) @(negedge clk100MHz);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({an, seg, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL midscan_reset_async: an=%b seg=%b dp=%b ft=%b, required 1111 1111111 1 0", an, seg, dp, frame_tick);
        end
        @(posedge clk100MHz);
        #1;
        tests_run++;
        if ({an, seg, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL midscan_reset_hold: an=%b seg=%b dp=%b ft=%b, required 1111 1111111 1 0", an, seg, dp, frame_tick);
        end
        @(negedge clk100MHz);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk100MHz);
            ea = ~(4'b0001 << (i / 4));
            tests_run++;
            if ({an, seg, frame_tick} !== {ea, 7'b1000000, (i == 15)}) begin
                tests_failed++;
                $display("FAIL midscan_release cyc%0d: an=%b seg=%b ft=%b, required %b 1000000 %b", i, an, seg, frame_tick, ea, (i == 15));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe_change();
        test_non_bcd_colon();
        test_blink();
        test_leading_zero();
        test_reset_midscan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
